// File: rtl/operand_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : operand_buffer                                                  |
// | Brief    : DEPTH-entry valid/ready operand FIFO with flush and occupancy    |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module operand_buffer #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] c_ptr_last = PW'(DEPTH - 1);
  localparam logic [CW-1:0] c_depth    = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic             w_push;
  logic             w_pop;
  logic [PW-1:0]    w_wr_ptr_nxt;
  logic [PW-1:0]    w_rd_ptr_nxt;

  // Status is derived from the count register only, so in_ready never sees out_ready.
  assign full      = (r_count == c_depth);
  assign empty     = (r_count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = r_count;
  assign out_data  = empty ? '0 : r_mem[r_rd_ptr];

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  // Explicit wrap so non-power-of-two depths work.
  assign w_wr_ptr_nxt = (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + PW'(1);
  assign w_rd_ptr_nxt = (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + PW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      // Flush discards any same-cycle push or pop; storage is left as is.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= in_data;
        r_wr_ptr        <= w_wr_ptr_nxt;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_operand_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_operand_buffer                                               |
// | Brief    : Directed + random bench for operand_buffer (4x16 and 3x8)        |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_operand_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default 4 x 16
  logic        a_in_valid = 1'b0, a_out_ready = 1'b0, a_flush = 1'b0;
  logic [15:0] a_in_data = '0;
  logic        a_in_ready, a_out_valid, a_full, a_empty;
  logic [15:0] a_out_data;
  logic [2:0]  a_count;

  // Instance B: non-power-of-two 3 x 8
  logic        b_in_valid = 1'b0, b_out_ready = 1'b0, b_flush = 1'b0;
  logic [7:0]  b_in_data = '0;
  logic        b_in_ready, b_out_valid, b_full, b_empty;
  logic [7:0]  b_out_data;
  logic [1:0]  b_count;

  operand_buffer #(.WIDTH(16), .DEPTH(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
    .flush(a_flush), .count(a_count), .full(a_full), .empty(a_empty)
  );

  operand_buffer #(.WIDTH(8), .DEPTH(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
    .flush(b_flush), .count(b_count), .full(b_full), .empty(b_empty)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: plain queues of stored words
  logic [15:0] q_a[$];
  logic [7:0]  q_b[$];
  bit push_a, pop_a, push_b, pop_b;
  logic [7:0] b_popped[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int na, nb;
    na = q_a.size();
    nb = q_b.size();
    check("a_count",     32'(a_count),     32'(na));
    check("a_empty",     32'(a_empty),     32'(na == 0));
    check("a_full",      32'(a_full),      32'(na == 4));
    check("a_in_ready",  32'(a_in_ready),  32'(na != 4));
    check("a_out_valid", 32'(a_out_valid), 32'(na != 0));
    check("a_out_data",  32'(a_out_data),  (na != 0) ? 32'(q_a[0]) : 32'h0);
    check("b_count",     32'(b_count),     32'(nb));
    check("b_full",      32'(b_full),      32'(nb == 3));
    check("b_out_valid", 32'(b_out_valid), 32'(nb != 0));
    check("b_out_data",  32'(b_out_data),  (nb != 0) ? 32'(q_b[0]) : 32'h0);
  endtask

  // One clock: decide model handshakes from pre-edge state, then compare after the edge.
  task automatic tick();
    push_a = a_in_valid && (q_a.size() < 4);
    pop_a  = a_out_ready && (q_a.size() > 0);
    push_b = b_in_valid && (q_b.size() < 3);
    pop_b  = b_out_ready && (q_b.size() > 0);
    @(posedge clk);
    #1;
    if (!rst_n || a_flush) begin
      q_a.delete();
    end else begin
      if (pop_a) void'(q_a.pop_front());
      if (push_a) q_a.push_back(a_in_data);
    end
    if (!rst_n || b_flush) begin
      q_b.delete();
    end else begin
      if (pop_b) b_popped.push_back(q_b.pop_front());
      if (push_b) q_b.push_back(b_in_data);
    end
    check_all();
  endtask

  initial begin
    int cyc;
    int next_b;

    // Reset held while the producer is active
    a_in_valid = 1'b1;
    a_in_data  = 16'hFFFF;
    b_in_valid = 1'b1;
    b_in_data  = 8'hFF;
    tick();
    tick();
    check("rst_a_in_ready", 32'(a_in_ready), 32'h1);
    check("rst_a_data",     32'(a_out_data), 32'h0);

    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // First push after reset
    a_in_valid = 1'b1;
    a_in_data  = 16'h1234;
    tick();
    check("first_push", 32'(a_out_data), 32'h1234);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;

    // Fill to full, then hold off a fifth word
    a_in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      a_in_data = 16'hA000 + 16'(i);
      tick();
    end
    check("fill_full", 32'(a_full), 32'h1);
    a_in_data = 16'hA005;
    tick();
    check("fill_held_count", 32'(a_count), 32'h4);

    // Pop at full with pending push: push rejected this edge
    a_out_ready = 1'b1;
    tick();
    check("full_pushpop_count", 32'(a_count), 32'h3);
    tick();
    check("full_push_next", 32'(a_count), 32'h3);
    a_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("drained", 32'(a_empty), 32'h1);
    a_out_ready = 1'b0;

    // Streaming at count 2 with pointer wrap
    a_in_valid = 1'b1;
    a_in_data  = 16'hC001;
    tick();
    a_in_data  = 16'hC002;
    tick();
    a_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_in_data = 16'(i);
      tick();
      check("stream_count", 32'(a_count), 32'h2);
    end
    a_in_valid = 1'b0;
    tick();
    tick();
    a_out_ready = 1'b0;

    // Flush with pending push and pop
    a_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_in_data = 16'hD000 + 16'(i);
      tick();
    end
    a_flush     = 1'b1;
    a_out_ready = 1'b1;
    a_in_data   = 16'hD0FF;
    tick();
    check("flush_empty", 32'(a_empty), 32'h1);
    check("flush_data",  32'(a_out_data), 32'h0);
    a_flush     = 1'b0;
    a_out_ready = 1'b0;
    a_in_data   = 16'hBEEF;
    tick();
    check("after_flush", 32'(a_out_data), 32'hBEEF);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;

    // Random traffic on A, producer holds until accepted
    for (int i = 0; i < 300; i++) begin
      if (!a_in_valid || push_a || a_flush) begin
        a_in_valid = ($urandom_range(0, 99) < 60);
        a_in_data  = 16'($urandom);
      end
      a_out_ready = ($urandom_range(0, 99) < 50);
      a_flush     = ($urandom_range(0, 99) < 4);
      tick();
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    a_flush     = 1'b0;

    // B: stream 01..0C with random out_ready
    next_b = 1;
    cyc    = 0;
    b_in_valid = 1'b1;
    b_in_data  = 8'h01;
    while ((b_popped.size() < 12) && (cyc < 400)) begin
      b_out_ready = ($urandom_range(0, 99) < 45);
      tick();
      check("b_count_max", 32'(b_count <= 2'd3), 32'h1);
      if (push_b) begin
        next_b++;
        b_in_valid = (next_b <= 12);
        b_in_data  = 8'(next_b);
      end
      cyc++;
    end
    b_in_valid  = 1'b0;
    b_out_ready = 1'b0;
    check("b_popped_total", 32'(b_popped.size()), 32'd12);
    for (int i = 0; i < b_popped.size(); i++) begin
      check("b_order", 32'(b_popped[i]), 32'(i + 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
